// File: rtl/tvip_axi_sample_write_responder.sv
// AXI write-side sink: queues AW bursts, counts W beats per burst and returns one B per burst in AW order.
// Optional TVIP_AXI_SAMPLE_WRITE_RESPONDER_STROBE_CHECK_EN flags beats with an all-zero strobe as SLVERR.
module tvip_axi_sample_write_responder #(
  parameter int ID_WIDTH   = 4,
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 8,
  parameter int AW_DEPTH   = 4,
  parameter int B_DEPTH    = 4
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_awvalid,
  output logic                    o_awready,
  input  logic [ID_WIDTH-1:0]     i_awid,
  input  logic [LEN_WIDTH-1:0]    i_awlen,
  input  logic                    i_wvalid,
  output logic                    o_wready,
  input  logic [DATA_WIDTH-1:0]   i_wdata,
  input  logic [DATA_WIDTH/8-1:0] i_wstrb,
  input  logic                    i_wlast,
  output logic                    o_bvalid,
  input  logic                    i_bready,
  output logic [ID_WIDTH-1:0]     o_bid,
  output logic [1:0]              o_bresp,
  output logic                    o_busy
);

  localparam int AW_PW = $clog2(AW_DEPTH);
  localparam int B_PW  = $clog2(B_DEPTH);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  logic [ID_WIDTH-1:0]  aw_id_mem  [AW_DEPTH];
  logic [LEN_WIDTH-1:0] aw_len_mem [AW_DEPTH];
  logic [AW_PW:0]       aw_wr;
  logic [AW_PW:0]       aw_rd;
  logic                 aw_empty;
  logic                 aw_full;
  logic                 aw_push;

  logic [ID_WIDTH-1:0]  b_id_mem   [B_DEPTH];
  logic [1:0]           b_resp_mem [B_DEPTH];
  logic [B_PW:0]        b_wr;
  logic [B_PW:0]        b_rd;
  logic                 b_empty;
  logic                 b_full;
  logic                 b_pop;

  logic                 ready_en;
  logic [LEN_WIDTH-1:0] count;
  logic                 err_flag;
  logic [ID_WIDTH-1:0]  head_id;
  logic [LEN_WIDTH-1:0] head_len;
  logic                 w_fire;
  logic                 at_len;
  logic                 final_beat;
  logic                 strobe_err;
  logic [1:0]           resp;
  logic                 unused_inputs;

  assign aw_empty = (aw_wr == aw_rd);
  assign aw_full  = (aw_wr[AW_PW] != aw_rd[AW_PW]) && (aw_wr[AW_PW-1:0] == aw_rd[AW_PW-1:0]);
  assign b_empty  = (b_wr == b_rd);
  assign b_full   = (b_wr[B_PW] != b_rd[B_PW]) && (b_wr[B_PW-1:0] == b_rd[B_PW-1:0]);

  // ready_en keeps awready low in the cycle after reset
  assign o_awready = ready_en && !aw_full;
  assign o_wready  = !aw_empty && !b_full;
  assign aw_push   = i_awvalid && o_awready;

  assign head_id    = aw_id_mem[aw_rd[AW_PW-1:0]];
  assign head_len   = aw_len_mem[aw_rd[AW_PW-1:0]];
  assign w_fire     = i_wvalid && o_wready;
  assign at_len     = (count == head_len);
  assign final_beat = w_fire && (at_len || i_wlast);

`ifdef TVIP_AXI_SAMPLE_WRITE_RESPONDER_STROBE_CHECK_EN
  assign strobe_err    = (i_wstrb == '0);
  assign unused_inputs = ^i_wdata;
`else
  assign strobe_err    = 1'b0;
  assign unused_inputs = ^{i_wdata, i_wstrb};
`endif

  // early WLAST and missing WLAST both show up as wlast disagreeing with the length match
  assign resp = (err_flag || strobe_err || (i_wlast != at_len)) ? RESP_SLVERR : RESP_OKAY;

  assign b_pop    = o_bvalid && i_bready;
  assign o_bvalid = !b_empty;
  assign o_bid    = b_empty ? '0 : b_id_mem[b_rd[B_PW-1:0]];
  assign o_bresp  = b_empty ? '0 : b_resp_mem[b_rd[B_PW-1:0]];
  assign o_busy   = !aw_empty || !b_empty || (count != '0);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      ready_en <= 1'b0;
      aw_wr    <= '0;
      aw_rd    <= '0;
      b_wr     <= '0;
      b_rd     <= '0;
      count    <= '0;
      err_flag <= 1'b0;
    end else begin
      ready_en <= 1'b1;
      if (aw_push) begin
        aw_wr <= aw_wr + 1'b1;
      end
      if (final_beat) begin
        aw_rd    <= aw_rd + 1'b1;
        b_wr     <= b_wr + 1'b1;
        count    <= '0;
        err_flag <= 1'b0;
      end else if (w_fire) begin
        count    <= count + LEN_WIDTH'(1);
        err_flag <= err_flag || strobe_err;
      end
      if (b_pop) begin
        b_rd <= b_rd + 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (aw_push) begin
      aw_id_mem[aw_wr[AW_PW-1:0]]  <= i_awid;
      aw_len_mem[aw_wr[AW_PW-1:0]] <= i_awlen;
    end
    if (i_rst_n && final_beat) begin
      b_id_mem[b_wr[B_PW-1:0]]   <= head_id;
      b_resp_mem[b_wr[B_PW-1:0]] <= resp;
    end
  end

endmodule

// File: tb/tb_tvip_axi_sample_write_responder.sv
// Scoreboard bench for tvip_axi_sample_write_responder: directed scenarios followed by randomized bursts.
module tb_tvip_axi_sample_write_responder;

  localparam int IDW = 4;
  localparam int DW  = 32;
  localparam int LW  = 8;

  logic            clk;
  logic            rst_n;
  logic            awvalid;
  logic            awready;
  logic [IDW-1:0]  awid;
  logic [LW-1:0]   awlen;
  logic            wvalid;
  logic            wready;
  logic [DW-1:0]   wdata;
  logic [DW/8-1:0] wstrb;
  logic            wlast;
  logic            bvalid;
  logic            bready;
  logic [IDW-1:0]  bid;
  logic [1:0]      bresp;
  logic            busy;

  tvip_axi_sample_write_responder #(
    .ID_WIDTH(IDW), .DATA_WIDTH(DW), .LEN_WIDTH(LW), .AW_DEPTH(4), .B_DEPTH(4)
  ) u_dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_awvalid(awvalid), .o_awready(awready), .i_awid(awid), .i_awlen(awlen),
    .i_wvalid(wvalid), .o_wready(wready), .i_wdata(wdata), .i_wstrb(wstrb), .i_wlast(wlast),
    .o_bvalid(bvalid), .i_bready(bready), .o_bid(bid), .o_bresp(bresp), .o_busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int id;
    int len;
    int nbeats;
    bit last_on_final;
    int zero_beat;
  } plan_t;

  typedef struct {
    int id;
    int resp;
  } exp_t;

  plan_t planq[$];
  exp_t  expq[$];
  int    tests = 0;
  int    fails = 0;
  bit    strobe_check_en;

  task automatic check(input string name, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic fail_now(input string name);
    tests++;
    fails++;
    $display("FAIL %s: got timeout expected handshake", name);
  endtask

  // Monitor: every presented B must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (rst_n && bvalid) begin
      if (expq.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL b_unexpected: got bid %0h expected none", bid);
      end else begin
        check("b_id", int'(bid), expq[0].id);
        check("b_resp", int'(bresp), expq[0].resp);
        if (bready) void'(expq.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_aw(input int id, input int len);
    int n = 0;
    awvalid = 1'b1;
    awid    = IDW'(id);
    awlen   = LW'(len);
    while (!awready && n < 5000) begin
      tick();
      n++;
    end
    if (!awready) fail_now("aw_timeout");
    tick();
    awvalid = 1'b0;
  endtask

  task automatic drive_w(input bit last, input int strb);
    int n = 0;
    wvalid = 1'b1;
    wlast  = last;
    wstrb  = (DW/8)'(strb);
    wdata  = $urandom;
    while (!wready && n < 5000) begin
      tick();
      n++;
    end
    if (!wready) fail_now("w_timeout");
    tick();
    wvalid = 1'b0;
    wlast  = 1'b0;
  endtask

  // Reference rule: a burst is OKAY only when exactly len+1 beats arrive, WLAST marks the last
  // of them, and (with strobe checking) no beat carries an all-zero strobe.
  task automatic issue(input int id, input int len, input int nbeats, input bit last_on_final,
                       input int zero_beat);
    plan_t p;
    exp_t  e;
    bit    err;
    err = (nbeats != len + 1) || !last_on_final;
    if (strobe_check_en && zero_beat >= 0 && zero_beat < nbeats) err = 1'b1;
    p.id = id; p.len = len; p.nbeats = nbeats; p.last_on_final = last_on_final; p.zero_beat = zero_beat;
    e.id = id;
    e.resp = err ? 2 : 0;
    expq.push_back(e);
    planq.push_back(p);
    drive_aw(id, len);
  endtask

  task automatic send_beats(input plan_t p, input bit gaps);
    for (int b = 0; b < p.nbeats; b++) begin
      if (gaps) repeat ($urandom_range(1, 0)) tick();
      drive_w((b == p.nbeats - 1) && p.last_on_final,
              (b == p.zero_beat) ? 0 : int'($urandom_range(15, 1)));
    end
  endtask

  task automatic run_pending();
    while (planq.size() != 0) send_beats(planq.pop_front(), 1'b0);
  endtask

  task automatic wait_drain();
    int n = 0;
    while (expq.size() != 0 && n < 3000) begin
      tick();
      n++;
    end
    if (expq.size() != 0) fail_now("b_drain");
  endtask

  initial begin
`ifdef TVIP_AXI_SAMPLE_WRITE_RESPONDER_STROBE_CHECK_EN
    strobe_check_en = 1'b1;
`else
    strobe_check_en = 1'b0;
`endif
    rst_n = 1'b0; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    awid = '0; awlen = '0; wdata = '0; wstrb = '1; wlast = 1'b1;

    // reset held with valids high
    for (int c = 0; c < 2; c++) begin
      tick();
      check("rst_awready", int'(awready), 0);
      check("rst_wready", int'(wready), 0);
      check("rst_bvalid", int'(bvalid), 0);
      check("rst_bid", int'(bid), 0);
      check("rst_bresp", int'(bresp), 0);
      check("rst_busy", int'(busy), 0);
    end
    rst_n = 1'b1; awvalid = 1'b0; wvalid = 1'b0; wlast = 1'b0; bready = 1'b0;
    tick();
    check("post_rst_awready", int'(awready), 1);
    check("post_rst_busy", int'(busy), 0);

    // single 4-beat burst, B one cycle after last beat
    issue(3, 3, 4, 1'b1, -1);
    check("busy_aw_queued", int'(busy), 1);
    run_pending();
    check("b_latency", int'(bvalid), 1);
    bready = 1'b1;
    wait_drain();

    // early WLAST, then a clean single-beat burst
    issue(1, 3, 2, 1'b1, -1);
    issue(2, 0, 1, 1'b1, -1);
    run_pending();
    wait_drain();

    // missing WLAST on a single-beat burst
    issue(4, 0, 1, 1'b0, -1);
    run_pending();
    wait_drain();

    // B queue full stalls W; AW keeps filling until its own queue is full
    bready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      issue(8 + i, 0, 1, 1'b1, -1);
      run_pending();
    end
    for (int i = 0; i < 4; i++) issue(12 + i, 0, 1, 1'b1, -1);
    check("full_awready", int'(awready), 0);
    check("full_wready", int'(wready), 0);
    check("full_bvalid", int'(bvalid), 1);
    bready = 1'b1;
    run_pending();
    wait_drain();

    // zero strobe
    issue(5, 0, 1, 1'b1, 0);
    run_pending();
    wait_drain();

    // reset mid-burst drops everything
    issue(6, 3, 4, 1'b1, -1);
    begin
      plan_t p;
      p = planq.pop_front();
      drive_w(1'b0, 15);
      drive_w(1'b0, 15);
    end
    check("mid_busy", int'(busy), 1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    expq.delete();
    planq.delete();
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_bvalid", int'(bvalid), 0);
    tick();
    issue(7, 1, 2, 1'b1, -1);
    run_pending();
    wait_drain();
    check("idle_busy", int'(busy), 0);

    // randomized bursts with concurrent AW, W and B traffic
    begin
      bit w_done = 1'b0;
      fork
        begin
          for (int i = 0; i < 60; i++) begin
            int len, mode, nb, zb;
            len  = (i == 0) ? 255 : int'($urandom_range(7, 0));
            mode = int'($urandom_range(9, 0));
            if (mode < 7 || (len == 0 && mode < 8)) mode = 0;
            else if (mode < 8 || len == 0) mode = 2;
            else mode = 1;
            nb = (mode == 1) ? int'($urandom_range(len - 1, 0)) + 1 : len + 1;
            zb = ($urandom_range(5, 0) == 0) ? int'($urandom_range(nb - 1, 0)) : -1;
            issue(int'($urandom_range(15, 0)), len, nb, mode != 2, zb);
            repeat ($urandom_range(2, 0)) tick();
          end
        end
        begin
          for (int i = 0; i < 60; i++) begin
            int n = 0;
            while (planq.size() == 0 && n < 20000) begin
              tick();
              n++;
            end
            if (planq.size() == 0) begin
              fail_now("plan_wait");
              break;
            end
            send_beats(planq.pop_front(), 1'b1);
          end
          w_done = 1'b1;
        end
        begin
          while (!w_done) begin
            tick();
            bready = ($urandom_range(3, 0) != 0);
          end
          bready = 1'b1;
        end
      join
    end
    wait_drain();
    tick();
    check("final_busy", int'(busy), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
